// File: rtl/i2c_codec_sequencer_if.sv
// Host / I2C-master side signals of the codec configuration sequencer.
// The sequencer takes the master modport; a host or test model takes slave.
interface i2c_codec_sequencer_if;
    logic        reinit_in;
    logic [15:0] cmd_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic        i2c_ready_in;
    logic [15:0] i2c_command_out;
    logic        i2c_load_out;
    logic        init_done_out;
    logic        busy_out;
    logic        error_out;
    logic [3:0]  init_index_out;

    modport master (
        input  reinit_in, cmd_in, cmd_valid_in, i2c_ready_in,
        output cmd_ready_out, i2c_command_out, i2c_load_out,
               init_done_out, busy_out, error_out, init_index_out
    );

    modport slave (
        output reinit_in, cmd_in, cmd_valid_in, i2c_ready_in,
        input  cmd_ready_out, i2c_command_out, i2c_load_out,
               init_done_out, busy_out, error_out, init_index_out
    );
endinterface

// File: rtl/i2c_codec_sequencer.sv
// Codec configuration sequencer: after a startup delay it walks an 11-entry
// register table through the I2C master, then forwards single host writes.
// Every transaction is supervised by a timeout; timeouts are recorded in a
// sticky error flag and the sequence simply moves on.
module i2c_codec_sequencer #(
    parameter int STARTUP_DELAY = 1024,
    parameter int TIMEOUT       = 4095,
    parameter int CNT_W         = 12
) (
    input logic                   mclk_in,
    input logic                   rst_n_in,
    i2c_codec_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO        = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LAST_IDX   = 4'd10;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_IDLE
    } state_e;

    typedef enum logic {
        SRC_INIT,
        SRC_HOST
    } src_e;

    // Fixed codec register table, {reg[6:0], data[8:0]} per entry.
    function automatic logic [15:0] init_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h1E00;
            4'd1:    return 16'h0C10;
            4'd2:    return 16'h0017;
            4'd3:    return 16'h0217;
            4'd4:    return 16'h0479;
            4'd5:    return 16'h0679;
            4'd6:    return 16'h0812;
            4'd7:    return 16'h0A00;
            4'd8:    return 16'h0E02;
            4'd9:    return 16'h1000;
            4'd10:   return 16'h1201;
            default: return 16'h0000;
        endcase
    endfunction

    // The shared counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [15:0]       host_cmd_q, host_cmd_d;
    logic [15:0]       cmd_q, cmd_d;
    logic              load_q, load_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              complete;
    logic              timed_out;
    logic              cmd_ready;

    // Host requests are only taken in IDLE with the master free; reinit has priority.
    assign cmd_ready = (state_q == ST_IDLE) && bus.i2c_ready_in && !bus.reinit_in;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        host_cmd_d = host_cmd_q;
        cmd_d      = cmd_q;
        load_d     = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        complete   = 1'b0;
        timed_out  = 1'b0;

        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    src_d   = SRC_INIT;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (bus.i2c_ready_in) begin
                    load_d  = 1'b1;
                    cmd_d   = (src_q == SRC_INIT) ? init_entry(idx_q) : host_cmd_q;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                cnt_d = sat_inc(cnt_q);
                if (!bus.i2c_ready_in) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q >= TMO) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = sat_inc(cnt_q);
                if (bus.i2c_ready_in) begin
                    complete = 1'b1;
                end else if (cnt_q >= TMO) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.reinit_in) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    src_d   = SRC_INIT;
                    state_d = ST_ISSUE;
                end else if (bus.cmd_valid_in && cmd_ready) begin
                    host_cmd_d = bus.cmd_in;
                    src_d      = SRC_HOST;
                    state_d    = ST_ISSUE;
                end
            end
            default: state_d = ST_STARTUP;
        endcase

        // A timed-out transaction finishes exactly like a successful one.
        if (complete) begin
            if (timed_out) begin
                err_d = 1'b1;
            end
            if (src_q == SRC_HOST) begin
                state_d = ST_IDLE;
            end else if (idx_q == LAST_IDX) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                idx_d   = idx_q + 4'd1;
                state_d = ST_ISSUE;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; the latched host word is plain data and not reset.
    always_ff @(posedge mclk_in) begin
        host_cmd_q <= host_cmd_d;
        if (!rst_n_in) begin
            state_q <= ST_STARTUP;
            src_q   <= SRC_INIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            cmd_q   <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            load_q  <= load_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.cmd_ready_out   = cmd_ready;
    assign bus.i2c_command_out = cmd_q;
    assign bus.i2c_load_out    = load_q;
    assign bus.init_done_out   = done_q;
    assign bus.busy_out        = busy_q;
    assign bus.error_out       = err_q;
    assign bus.init_index_out  = idx_q;

endmodule

// File: tb/tb_i2c_codec_sequencer.sv
// Self-checking bench for i2c_codec_sequencer with a behavioural I2C master.
module tb_i2c_codec_sequencer;

    localparam int SD   = 500;   // startup delay used for this bench
    localparam int TO   = 600;   // per-transaction timeout
    localparam int MLAT = 400;   // master busy time after a load

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_codec_sequencer_if sif();

    i2c_codec_sequencer #(
        .STARTUP_DELAY(SD),
        .TIMEOUT(TO),
        .CNT_W(12)
    ) dut (
        .mclk_in(clk),
        .rst_n_in(rst_n),
        .bus(sif)
    );

    logic [15:0] init_tab [11] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                   16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201};

    int checks = 0;
    int failures = 0;

    // Behavioural I2C master: drops ready one cycle after a load, raises it MLAT cycles later.
    logic m_ready = 1'b1;
    int   m_cnt = 0;
    bit   stuck = 1'b0;
    assign sif.i2c_ready_in = m_ready;
    always @(negedge clk) begin
        if (sif.i2c_load_out === 1'b1 && !stuck) begin
            m_ready = 1'b0;
            m_cnt = MLAT;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_ready = 1'b1;
        end
    end

    // Record every command the master is asked to load, and any stretched load strobe.
    logic [15:0] loads[$];
    logic prev_load = 1'b0;
    int   dbl = 0;
    always @(negedge clk) begin
        if (sif.i2c_load_out === 1'b1) loads.push_back(sif.i2c_command_out);
        if (sif.i2c_load_out === 1'b1 && prev_load) dbl++;
        prev_load = (sif.i2c_load_out === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sif.reinit_in = 1'b0;
        sif.cmd_valid_in = 1'b0;
        sif.cmd_in = 16'h0000;
        repeat (3) tick();
        checks++; if (sif.i2c_load_out !== 1'b0) begin failures++; $display("FAIL reset_load got=%b want=0", sif.i2c_load_out); end
        checks++; if (sif.i2c_command_out !== 16'h0000) begin failures++; $display("FAIL reset_cmd got=%h want=0000", sif.i2c_command_out); end
        checks++; if (sif.init_done_out !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", sif.init_done_out); end
        checks++; if (sif.error_out !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", sif.error_out); end
        checks++; if (sif.busy_out !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", sif.busy_out); end
        checks++; if (sif.cmd_ready_out !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b want=0", sif.cmd_ready_out); end
        checks++; if (sif.init_index_out !== 4'd0) begin failures++; $display("FAIL reset_index got=%0d want=0", sif.init_index_out); end
    endtask

    task automatic test_startup_and_init();
        int n = 0;
        bit early = 1'b0;
        bit seen = 1'b0;
        loads.delete();
        rst_n = 1'b1;
        // The first edge sampling the release is edge 1; the load shows SD edges after it.
        for (int k = 0; k < SD + 50; k++) begin
            tick(); n++;
            if (sif.i2c_load_out === 1'b1) break;
        end
        checks++; if (n !== SD + 1) begin failures++; $display("FAIL startup_delay got=%0d want=%0d", n, SD + 1); end
        for (int k = 0; k < 11 * (MLAT + 10) + 100; k++) begin
            tick();
            if (sif.init_done_out === 1'b1) begin
                seen = 1'b1;
                if (loads.size() != 11 || m_ready !== 1'b1) early = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL init_done_timeout got=%b want=1", seen); end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL init_done_early loads=%0d ready=%b want 11/1", loads.size(), m_ready); end
        checks++; if (loads.size() !== 11) begin failures++; $display("FAIL init_count got=%0d want=11", loads.size()); end
        for (int i = 0; i < 11; i++) begin
            logic [15:0] got;
            got = (i < loads.size()) ? loads[i] : 16'hxxxx;
            checks++; if (got !== init_tab[i]) begin failures++; $display("FAIL init_entry[%0d] got=%h want=%h", i, got, init_tab[i]); end
        end
        checks++; if (sif.error_out !== 1'b0) begin failures++; $display("FAIL init_err got=%b want=0", sif.error_out); end
    endtask

    task automatic test_host_write();
        for (int t = 0; t < 4; t++) begin
            logic [15:0] c;
            logic r0, r1, b1;
            bit idle = 1'b0;
            c = (t == 0) ? 16'h0479 : 16'($urandom);
            loads.delete();
            tick();
            sif.cmd_in = c;
            sif.cmd_valid_in = 1'b1;
            #1;
            r0 = sif.cmd_ready_out;
            tick();
            r1 = sif.cmd_ready_out;
            b1 = sif.busy_out;
            sif.cmd_valid_in = 1'b0;
            for (int k = 0; k < MLAT + 30; k++) begin
                tick();
                if (sif.busy_out === 1'b0) begin idle = 1'b1; break; end
            end
            checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL host_ready_on got=%b want=1", r0); end
            checks++; if (r1 !== 1'b0) begin failures++; $display("FAIL host_ready_once got=%b want=0", r1); end
            checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL host_busy got=%b want=1", b1); end
            checks++; if (idle !== 1'b1) begin failures++; $display("FAIL host_idle_timeout got=%b want=1", idle); end
            checks++; if (loads.size() !== 1) begin failures++; $display("FAIL host_load_count got=%0d want=1", loads.size()); end
            checks++; if ((loads.size() > 0 ? loads[0] : 16'hxxxx) !== c) begin failures++; $display("FAIL host_cmd got=%h want=%h", (loads.size() > 0 ? loads[0] : 16'hxxxx), c); end
            checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL host_idle_before_ready got=%b want=1", m_ready); end
        end
    endtask

    task automatic test_host_during_init();
        logic [15:0] c;
        bit at3 = 1'b0, seen = 1'b0, idle = 1'b0;
        logic done_at = 1'b0;
        c = 16'($urandom);
        loads.delete();
        tick();
        sif.reinit_in = 1'b1;
        tick();
        sif.reinit_in = 1'b0;
        for (int k = 0; k < 4 * (MLAT + 10); k++) begin
            tick();
            if (sif.init_index_out === 4'd3) begin at3 = 1'b1; break; end
        end
        sif.cmd_in = c;
        sif.cmd_valid_in = 1'b1;
        for (int k = 0; k < 11 * (MLAT + 10); k++) begin
            tick();
            if (sif.cmd_ready_out === 1'b1) begin seen = 1'b1; done_at = sif.init_done_out; break; end
        end
        tick();
        sif.cmd_valid_in = 1'b0;
        for (int k = 0; k < MLAT + 30; k++) begin
            tick();
            if (sif.busy_out === 1'b0) begin idle = 1'b1; break; end
        end
        checks++; if (at3 !== 1'b1) begin failures++; $display("FAIL mid_reach_index3 got=%b want=1", at3); end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL mid_accept_timeout got=%b want=1", seen); end
        checks++; if (done_at !== 1'b1) begin failures++; $display("FAIL mid_accept_before_done got=%b want=1", done_at); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle_timeout got=%b want=1", idle); end
        checks++; if (loads.size() !== 12) begin failures++; $display("FAIL mid_load_count got=%0d want=12", loads.size()); end
        for (int i = 0; i < 11; i++) begin
            logic [15:0] got;
            got = (i < loads.size()) ? loads[i] : 16'hxxxx;
            checks++; if (got !== init_tab[i]) begin failures++; $display("FAIL mid_entry[%0d] got=%h want=%h", i, got, init_tab[i]); end
        end
        checks++; if ((loads.size() > 11 ? loads[11] : 16'hxxxx) !== c) begin failures++; $display("FAIL mid_host_cmd got=%h want=%h", (loads.size() > 11 ? loads[11] : 16'hxxxx), c); end
    endtask

    task automatic test_timeout();
        int n = 0, first_load = -1, first_err = -1;
        bit seen = 1'b0;
        stuck = 1'b1;
        loads.delete();
        tick();
        sif.reinit_in = 1'b1;
        tick();
        sif.reinit_in = 1'b0;
        for (int k = 0; k < 11 * (TO + 10) + 100; k++) begin
            tick(); n++;
            if (sif.i2c_load_out === 1'b1 && first_load < 0) first_load = n;
            if (sif.error_out === 1'b1 && first_err < 0) first_err = n;
            if (sif.init_done_out === 1'b1) begin seen = 1'b1; break; end
        end
        stuck = 1'b0;
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL tmo_done_timeout got=%b want=1", seen); end
        checks++; if (!(first_err - first_load >= TO && first_err - first_load <= TO + 2)) begin
            failures++; $display("FAIL tmo_latency got=%0d want=%0d..%0d", first_err - first_load, TO, TO + 2); end
        checks++; if (sif.error_out !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b want=1", sif.error_out); end
        checks++; if (loads.size() !== 11) begin failures++; $display("FAIL tmo_load_count got=%0d want=11", loads.size()); end
        for (int i = 0; i < 11; i++) begin
            logic [15:0] got;
            got = (i < loads.size()) ? loads[i] : 16'hxxxx;
            checks++; if (got !== init_tab[i]) begin failures++; $display("FAIL tmo_entry[%0d] got=%h want=%h", i, got, init_tab[i]); end
        end
    endtask

    task automatic test_reinit_priority();
        logic [15:0] c;
        logic r0;
        int n = 0;
        bit seen = 1'b0;
        c = 16'($urandom);
        tick();
        loads.delete();
        sif.cmd_in = c;
        sif.cmd_valid_in = 1'b1;
        sif.reinit_in = 1'b1;
        #1;
        r0 = sif.cmd_ready_out;
        tick();
        sif.reinit_in = 1'b0;
        sif.cmd_valid_in = 1'b0;
        checks++; if (r0 !== 1'b0) begin failures++; $display("FAIL reinit_blocks_host got=%b want=0", r0); end
        checks++; if (sif.init_done_out !== 1'b0) begin failures++; $display("FAIL reinit_done got=%b want=0", sif.init_done_out); end
        checks++; if (sif.error_out !== 1'b0) begin failures++; $display("FAIL reinit_err got=%b want=0", sif.error_out); end
        checks++; if (sif.busy_out !== 1'b1) begin failures++; $display("FAIL reinit_busy got=%b want=1", sif.busy_out); end
        checks++; if (sif.init_index_out !== 4'd0) begin failures++; $display("FAIL reinit_index got=%0d want=0", sif.init_index_out); end
        for (int k = 0; k < 10; k++) begin
            tick(); n++;
            if (sif.i2c_load_out === 1'b1) break;
        end
        checks++; if (n > 2) begin failures++; $display("FAIL reinit_no_delay got=%0d want<=2", n); end
        for (int k = 0; k < 11 * (MLAT + 10) + 100; k++) begin
            tick();
            if (sif.init_done_out === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL reinit_done_timeout got=%b want=1", seen); end
        checks++; if (loads.size() !== 11) begin failures++; $display("FAIL reinit_load_count got=%0d want=11", loads.size()); end
        for (int i = 0; i < 11; i++) begin
            logic [15:0] got;
            got = (i < loads.size()) ? loads[i] : 16'hxxxx;
            checks++; if (got !== init_tab[i]) begin failures++; $display("FAIL reinit_entry[%0d] got=%h want=%h", i, got, init_tab[i]); end
        end
        checks++; if (sif.error_out !== 1'b0) begin failures++; $display("FAIL reinit_err_after got=%b want=0", sif.error_out); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit at5 = 1'b0, seen = 1'b0;
        loads.delete();
        tick();
        sif.reinit_in = 1'b1;
        tick();
        sif.reinit_in = 1'b0;
        for (int k = 0; k < 7 * (MLAT + 10); k++) begin
            tick();
            if (loads.size() == 6) begin at5 = 1'b1; break; end
        end
        repeat (50) tick();
        checks++; if (at5 !== 1'b1 || sif.init_index_out !== 4'd5 || m_ready !== 1'b0) begin
            failures++; $display("FAIL rmid_position index=%0d ready=%b want 5/0", sif.init_index_out, m_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (sif.i2c_load_out !== 1'b0) begin failures++; $display("FAIL rmid_load got=%b want=0", sif.i2c_load_out); end
        checks++; if (sif.i2c_command_out !== 16'h0000) begin failures++; $display("FAIL rmid_cmd got=%h want=0000", sif.i2c_command_out); end
        checks++; if (sif.init_done_out !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b want=0", sif.init_done_out); end
        checks++; if (sif.error_out !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b want=0", sif.error_out); end
        checks++; if (sif.busy_out !== 1'b1) begin failures++; $display("FAIL rmid_busy got=%b want=1", sif.busy_out); end
        checks++; if (sif.cmd_ready_out !== 1'b0) begin failures++; $display("FAIL rmid_cmd_ready got=%b want=0", sif.cmd_ready_out); end
        checks++; if (sif.init_index_out !== 4'd0) begin failures++; $display("FAIL rmid_index got=%0d want=0", sif.init_index_out); end
        loads.delete();
        for (int k = 0; k < SD + 50; k++) begin
            tick(); n++;
            if (sif.i2c_load_out === 1'b1) break;
        end
        checks++; if (n !== SD + 1) begin failures++; $display("FAIL rmid_startup_delay got=%0d want=%0d", n, SD + 1); end
        for (int k = 0; k < 11 * (MLAT + 10) + 100; k++) begin
            tick();
            if (sif.init_done_out === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rmid_done_timeout got=%b want=1", seen); end
        checks++; if (loads.size() !== 11) begin failures++; $display("FAIL rmid_load_count got=%0d want=11", loads.size()); end
        for (int i = 0; i < 11; i++) begin
            logic [15:0] got;
            got = (i < loads.size()) ? loads[i] : 16'hxxxx;
            checks++; if (got !== init_tab[i]) begin failures++; $display("FAIL rmid_entry[%0d] got=%h want=%h", i, got, init_tab[i]); end
        end
        checks++; if (dbl !== 0) begin failures++; $display("FAIL load_pulse_width got=%0d stretched want=0", dbl); end
    endtask

    initial begin
        sif.reinit_in = 1'b0;
        sif.cmd_valid_in = 1'b0;
        sif.cmd_in = 16'h0000;
        test_reset();
        test_startup_and_init();
        test_host_write();
        test_host_during_init();
        test_timeout();
        test_reinit_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_codec_sequencer.md
Name: i2c_codec_sequencer

Overview:
Controller that sequences the I2C master to configure the audio codec at I2C address 0x34.
- After reset and a startup delay, walks a fixed 11-entry table of 16-bit register commands, one I2C transaction per entry.
- After init, arbitrates single host register writes (volume, mute, etc.) onto the same master.
- Supervises every transaction with a timeout.
- Sits between top-level control logic and the I2C master's command/load/ready interface.

Parameters:
STARTUP_DELAY, 1024, mclk_in cycles to wait after reset release before the first table entry.
TIMEOUT, 4095, maximum mclk_in cycles allowed per transaction (load to ready high) before abandoning it.
CNT_W, 12, width of the shared delay/timeout counter; must satisfy 2^CNT_W > max(STARTUP_DELAY, TIMEOUT).

Ports:
mclk_in  input  1  system clock; all logic on rising edge
rst_n_in  input  1  reset, synchronous, active-low
reinit_in  input  1  one-cycle pulse: rerun the init table (honoured only in IDLE)
cmd_in  input  16  host command {reg[6:0], data[8:0]}
cmd_valid_in  input  1  host command request; held high until accepted
cmd_ready_out  output  1  host command accepted this cycle when high together with cmd_valid_in
i2c_ready_in  input  1  ready from the I2C master
i2c_command_out  output  16  command to the I2C master
i2c_load_out  output  1  one-cycle load strobe to the I2C master
init_done_out  output  1  high once the table has completed
busy_out  output  1  high in any state except IDLE
error_out  output  1  sticky: at least one transaction timed out
init_index_out  output  4  current table index (debug)

Behaviour:
- Reset values (rst_n_in low at a rising edge): state=STARTUP, counter=0, index=0, i2c_load_out=0, i2c_command_out=0, init_done_out=0, error_out=0, busy_out=1, cmd_ready_out=0.
- Init table, index 0..10, fixed contents: 0x1E00, 0x0C10, 0x0017, 0x0217, 0x0479, 0x0679, 0x0812, 0x0A00, 0x0E02, 0x1000, 0x1201.
- States: STARTUP, ISSUE, WAIT_BUSY, WAIT_DONE, IDLE. A source flag records whether the current transaction is INIT or HOST.
- STARTUP:
  - Counter increments each cycle.
  - When counter == STARTUP_DELAY-1: clear counter, set source=INIT, go to ISSUE.
- ISSUE:
  - Stays in ISSUE while i2c_ready_in is low, with i2c_load_out=0.
  - When i2c_ready_in is high: drive i2c_load_out=1 for exactly one cycle, with i2c_command_out stable (table[index] or the latched host command). Clear counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - Waits for i2c_ready_in==0, then goes to WAIT_DONE.
  - The counter keeps running from ISSUE and is not cleared on entry to WAIT_DONE.
- WAIT_DONE:
  - Waits for i2c_ready_in==1, which marks transaction complete.
  - On completion with source=INIT: if index==10, set init_done_out=1 and go to IDLE; otherwise increment index and go to ISSUE.
  - On completion with source=HOST: go to IDLE.
- Timeout: in WAIT_BUSY or WAIT_DONE, if counter reaches TIMEOUT:
  - set error_out=1;
  - treat the transaction as complete (same next-state rules);
  - the table continues with the next entry and is not retried.
- i2c_command_out holds its value from ISSUE through the end of WAIT_DONE.
- Latency: i2c_load_out rises in the cycle after entering ISSUE with ready high. Minimum is 1 cycle from STARTUP expiry or host acceptance.
- IDLE:
  - cmd_ready_out = (state==IDLE) && i2c_ready_in && !reinit_in. This is combinational.
  - On cmd_valid_in && cmd_ready_out: latch cmd_in, set source=HOST, go to ISSUE.
  - On reinit_in: clear init_done_out, error_out and index; set source=INIT; go to ISSUE. There is no startup delay.
  - reinit_in and cmd_valid_in in the same cycle: reinit wins and the host command is not accepted.
- reinit_in outside IDLE is ignored.
- cmd_valid_in during init or during a transaction: cmd_ready_out=0 and the request waits.
- Reset mid-transaction returns to STARTUP immediately. The I2C master is not reset by this block; the next ISSUE waits for i2c_ready_in high.
- Counter saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Reset, then release with a master model (ready drops 1 cycle after load, returns 400 cycles later) -> first i2c_load_out exactly STARTUP_DELAY cycles after release. 11 loads in table order 0x1E00…0x1201. init_done_out=1 after the 11th ready return; error_out=0.
- After init, cmd_in=0x0479 with cmd_valid_in=1 -> cmd_ready_out=1 for one cycle, one load with command 0x0479, busy_out high until ready returns, then IDLE.
- Host request asserted at index 3 of init -> cmd_ready_out stays 0 until init_done_out=1. The host load is the 12th load, carrying the host command.
- Master model holds ready high after load (never goes busy) -> error_out=1 after TIMEOUT cycles, index advances, remaining entries are issued, init_done_out=1.
- reinit_in and cmd_valid_in both high in IDLE -> host not accepted, error_out and init_done_out cleared, table reissued from 0x1E00 with no startup delay.
- rst_n_in low for 1 cycle during WAIT_DONE of entry 5 -> all outputs at reset values next cycle; sequence restarts with STARTUP delay from entry 0.
